// File: rtl/bpsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_rx_ctrl
// Description : BPSK receive framer. Hunts for a sync word in the hard-decision
//               bit stream, then assembles frame_len payload bytes and hands
//               them downstream with a valid/ready handshake.
//               Optional build macro BPSK_RX_PHASE_INV_EN: also lock on the
//               inverted sync word and invert the payload of that frame.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_rx_ctrl #(
    parameter logic [7:0] SYNC_WORD = 8'hD3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sym_stb,
    input  logic       bit_in,
    input  logic [3:0] frame_len,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       locked,
    output logic       frame_done,
    output logic       overflow
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HUNT    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0] r_state,    w_state_nxt;
    logic [7:0] r_shift,    w_shift_nxt;
    logic [3:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic [4:0] r_len,      w_len_nxt;
    logic [4:0] r_byte_cnt, w_byte_cnt_nxt;
    logic       w_byte_done;
    logic [7:0] w_hunt_shift;
    logic       w_match_pos;
    logic       w_pay_bit;

    logic [7:0] r_byte_data;
    logic       r_byte_valid;
    logic       r_frame_done;
    logic       r_overflow;

    // Candidate sync window: the hunt register with the current bit appended.
    assign w_hunt_shift = {r_shift[6:0], bit_in};
    assign w_match_pos  = (w_hunt_shift == SYNC_WORD);

`ifdef BPSK_RX_PHASE_INV_EN
    logic r_pol, w_pol_nxt;
    logic w_match_neg;
    assign w_match_neg = (w_hunt_shift == ~SYNC_WORD);
    assign w_pay_bit   = bit_in ^ r_pol;

    // Polarity flag: set when the frame locked on the inverted sync word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pol <= 1'b0;
        else        r_pol <= w_pol_nxt;
    end
`else
    assign w_pay_bit = bit_in;
`endif

    // Next-state logic for the framer FSM, hunt/assembly shifter and counters.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_len_nxt      = r_len;
        w_byte_cnt_nxt = r_byte_cnt;
        w_byte_done    = 1'b0;
`ifdef BPSK_RX_PHASE_INV_EN
        w_pol_nxt      = r_pol;
`endif
        if (!enable) begin
            w_state_nxt    = S_IDLE;
            w_shift_nxt    = 8'd0;
            w_bit_cnt_nxt  = 4'd0;
            w_len_nxt      = 5'd0;
            w_byte_cnt_nxt = 5'd0;
`ifdef BPSK_RX_PHASE_INV_EN
            w_pol_nxt      = 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_HUNT;
                end
                S_HUNT: begin
                    if (sym_stb) begin
                        w_shift_nxt   = w_hunt_shift;
                        w_bit_cnt_nxt = (r_bit_cnt == 4'd8) ? 4'd8 : r_bit_cnt + 4'd1;
                        // The bit count gate keeps the zeroed register from
                        // matching before a full window has been received.
                        if (w_bit_cnt_nxt == 4'd8 && w_match_pos) begin
                            w_state_nxt = S_PAYLOAD;
                        end
`ifdef BPSK_RX_PHASE_INV_EN
                        if (w_bit_cnt_nxt == 4'd8 && !w_match_pos && w_match_neg) begin
                            w_state_nxt = S_PAYLOAD;
                            w_pol_nxt   = 1'b1;
                        end
`endif
                        if (w_state_nxt == S_PAYLOAD) begin
                            w_shift_nxt    = 8'd0;
                            w_bit_cnt_nxt  = 4'd0;
                            w_byte_cnt_nxt = 5'd0;
                            w_len_nxt      = (frame_len == 4'd0) ? 5'd16 : {1'b0, frame_len};
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (sym_stb) begin
                        w_shift_nxt = {r_shift[6:0], w_pay_bit};
                        if (r_bit_cnt == 4'd7) begin
                            w_byte_done    = 1'b1;
                            w_bit_cnt_nxt  = 4'd0;
                            w_byte_cnt_nxt = r_byte_cnt + 5'd1;
                            if (r_byte_cnt + 5'd1 == r_len) w_state_nxt = S_DONE;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    // DONE: strobes ignored, restart the hunt from scratch.
                    w_state_nxt    = S_HUNT;
                    w_shift_nxt    = 8'd0;
                    w_bit_cnt_nxt  = 4'd0;
                    w_byte_cnt_nxt = 5'd0;
`ifdef BPSK_RX_PHASE_INV_EN
                    w_pol_nxt      = 1'b0;
`endif
                end
            endcase
        end
    end

    // State, shifter and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 4'd0;
            r_len      <= 5'd0;
            r_byte_cnt <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_len      <= w_len_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
        end
    end

    // Output holding register: load on completion unless a byte is stuck
    // unaccepted, in which case the new byte is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_data  <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= (r_state == S_PAYLOAD) && (w_state_nxt == S_DONE);
            r_overflow   <= 1'b0;
            if (!enable) begin
                r_byte_valid <= 1'b0;
            end else if (w_byte_done) begin
                if (!r_byte_valid || byte_ready) begin
                    r_byte_data  <= w_shift_nxt;
                    r_byte_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_byte_valid && byte_ready) begin
                r_byte_valid <= 1'b0;
            end
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign locked     = (r_state == S_PAYLOAD);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_rx_ctrl
// Description : Self-checking bench for bpsk_rx_ctrl: vector table, directed
//               corner sequences and a randomized stream against a frame-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_rx_ctrl;

    localparam logic [7:0] SYNC = 8'hD3;
`ifdef BPSK_RX_PHASE_INV_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sym_stb;
    logic       bit_in;
    logic [3:0] frame_len;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       locked;
    logic       frame_done;
    logic       overflow;

    bpsk_rx_ctrl #(.SYNC_WORD(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sym_stb    (sym_stb),
        .bit_in     (bit_in),
        .frame_len  (frame_len),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .locked     (locked),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Output monitor: every handshake, frame_done and overflow pulse.
    logic [7:0] got_q[$];
    int fd_cnt = 0;
    int ov_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid && byte_ready) got_q.push_back(byte_data);
            if (frame_done) fd_cnt++;
            if (overflow)   ov_cnt++;
        end
    end

    typedef struct {
        logic [7:0] sync;
        logic [3:0] flen;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         lock;
        bit         inv;
    } vec_t;
    vec_t vecs[6];

    typedef struct {
        int   c;
        logic b;
    } ev_t;
    ev_t        ev_q[$];
    logic       bq[$];
    logic [7:0] exp_q[$];

    int qb, fb, ob, nexp, rlen, nj, mode, n, got, dcyc, nfr;
    logic [7:0] win, acc, sw, ed;
    logic       pol;
    bit         el;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic stb, input logic b);
        sym_stb = stb;
        bit_in  = b;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(1'b1, b[i]);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        step(1'b0, 1'b0);
        enable = 1'b1;
        step(1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hD3, 4'd1, 8'hA5, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hD3, 4'd2, 8'h3C, 8'hC3, 1'b1, 1'b0};
        vecs[2] = '{8'h2C, 4'd1, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hD2, 4'd1, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hD3, 4'd1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hD3, 4'd2, 8'hFF, 8'h80, 1'b1, 1'b0};

        rst_n = 1'b0; enable = 1'b1; sym_stb = 1'b0; bit_in = 1'b0;
        frame_len = 4'd1; byte_ready = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        check("reset locked",     {31'd0, locked},     32'd0);
        check("reset byte_valid", {31'd0, byte_valid}, 32'd0);
        check("reset byte_data",  {24'd0, byte_data},  32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        check("reset overflow",   {31'd0, overflow},   32'd0);
        rst_n = 1'b1;

        // Basic frame with exact latency checks.
        go_idle();
        frame_len = 4'd1; byte_ready = 1'b1;
        for (int i = 7; i >= 1; i--) step(1'b1, SYNC[i]);
        check("lock before 8th", {31'd0, locked}, 32'd0);
        step(1'b1, SYNC[0]);
        check("lock after 8th", {31'd0, locked}, 32'd1);
        ed = 8'hA5;
        for (int i = 7; i >= 1; i--) step(1'b1, ed[i]);
        check("valid before 16th", {31'd0, byte_valid}, 32'd0);
        step(1'b1, ed[0]);
        check("latency valid",  {31'd0, byte_valid}, 32'd1);
        check("latency data",   {24'd0, byte_data},  32'hA5);
        check("latency fdone",  {31'd0, frame_done}, 32'd1);
        step(1'b0, 1'b0);
        check("post valid drop", {31'd0, byte_valid}, 32'd0);
        check("post fdone drop", {31'd0, frame_done}, 32'd0);
        check("post unlocked",   {31'd0, locked},     32'd0);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            go_idle();
            frame_len = vecs[v].flen; byte_ready = 1'b1;
            qb = got_q.size(); fb = fd_cnt;
            el = vecs[v].lock || (vecs[v].inv && INV);
            send_byte(vecs[v].sync);
            check($sformatf("vec%0d lock", v), {31'd0, locked}, {31'd0, el});
            send_byte(vecs[v].d0);
            if (vecs[v].flen == 4'd2) send_byte(vecs[v].d1);
            repeat (3) step(1'b0, 1'b0);
            nexp = el ? int'(vecs[v].flen) : 0;
            check($sformatf("vec%0d nbytes", v), got_q.size() - qb, nexp);
            if (el && got_q.size() > qb) begin
                ed = vecs[v].inv ? ~vecs[v].d0 : vecs[v].d0;
                check($sformatf("vec%0d byte0", v), {24'd0, got_q[qb]}, {24'd0, ed});
            end
            if (el && vecs[v].flen == 4'd2 && got_q.size() > qb + 1) begin
                check($sformatf("vec%0d byte1", v), {24'd0, got_q[qb+1]}, {24'd0, vecs[v].d1});
            end
            check($sformatf("vec%0d frames", v), fd_cnt - fb, el ? 1 : 0);
            check($sformatf("vec%0d unlock", v), {31'd0, locked}, 32'd0);
        end

        // frame_len = 0 means 16 bytes.
        go_idle();
        frame_len = 4'd0; byte_ready = 1'b1;
        qb = got_q.size(); fb = fd_cnt;
        send_byte(SYNC);
        for (int k = 0; k < 15; k++) send_byte(8'(k));
        step(1'b0, 1'b0);
        check("len16 no early done", fd_cnt - fb, 0);
        check("len16 still locked", {31'd0, locked}, 32'd1);
        send_byte(8'h0F);
        repeat (3) step(1'b0, 1'b0);
        check("len16 frames", fd_cnt - fb, 1);
        check("len16 nbytes", got_q.size() - qb, 16);
        for (int k = 0; k < 16; k++)
            if (qb + k < got_q.size())
                check($sformatf("len16 byte%0d", k), {24'd0, got_q[qb+k]}, k);

        // Backpressure: second byte dropped, first held through DONE->HUNT.
        go_idle();
        frame_len = 4'd2; byte_ready = 1'b0;
        ob = ov_cnt;
        send_byte(SYNC);
        send_byte(8'h3C);
        send_byte(8'h96);
        check("ovf pulse", {31'd0, overflow}, 32'd1);
        check("ovf held data", {24'd0, byte_data}, 32'h3C);
        repeat (4) step(1'b0, 1'b0);
        check("ovf valid survives", {31'd0, byte_valid}, 32'd1);
        check("ovf data survives", {24'd0, byte_data}, 32'h3C);
        check("ovf count", ov_cnt - ob, 1);
        byte_ready = 1'b1;
        step(1'b0, 1'b0);
        check("ovf accepted", {31'd0, byte_valid}, 32'd0);

        // Accept and completion in the same cycle.
        go_idle();
        frame_len = 4'd2; byte_ready = 1'b0;
        ob = ov_cnt;
        send_byte(SYNC);
        send_byte(8'h11);
        ed = 8'h22;
        for (int i = 7; i >= 1; i--) step(1'b1, ed[i]);
        check("same held 0x11", {24'd0, byte_data}, 32'h11);
        byte_ready = 1'b1;
        step(1'b1, ed[0]);
        check("same valid", {31'd0, byte_valid}, 32'd1);
        check("same data",  {24'd0, byte_data},  32'h22);
        check("same no ovf", ov_cnt - ob, 0);
        step(1'b0, 1'b0);
        check("same drained", {31'd0, byte_valid}, 32'd0);

        // Enable dropped mid-payload, then reset, then relock.
        go_idle();
        frame_len = 4'd1; byte_ready = 1'b1;
        send_byte(SYNC);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        enable = 1'b0;
        step(1'b0, 1'b0);
        check("dis locked", {31'd0, locked},     32'd0);
        check("dis valid",  {31'd0, byte_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst data",  {24'd0, byte_data},  32'd0);
        check("rst flags", {28'd0, byte_valid, locked, frame_done, overflow}, 32'd0);
        step(1'b0, 1'b0);
        rst_n = 1'b1; enable = 1'b1;
        step(1'b0, 1'b0);
        qb = got_q.size();
        send_byte(8'hA5);
        send_byte(8'h5A);
        check("relock needs sync", {31'd0, locked}, 32'd0);
        send_byte(SYNC);
        check("relock", {31'd0, locked}, 32'd1);
        send_byte(8'h77);
        step(1'b0, 1'b0);
        check("relock nbytes", got_q.size() - qb, 1);
        if (got_q.size() > qb) check("relock byte", {24'd0, got_q[qb]}, 32'h77);

        // Randomized streams against a frame-level model.
        for (int run = 0; run < 4; run++) begin
            go_idle();
            byte_ready = 1'b1;
            rlen = $urandom_range(1, 3);
            frame_len = 4'(rlen);
            ev_q.delete(); bq.delete();
            qb = got_q.size(); fb = fd_cnt; ob = ov_cnt;
            for (int seg = 0; seg < 6; seg++) begin
                nj = $urandom_range(0, 10);
                for (int j = 0; j < nj; j++) bq.push_back(1'($urandom_range(0, 1)));
                sw = SYNC;
                if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, 7)] ^= 1'b1;
                for (int j = 7; j >= 0; j--) bq.push_back(sw[j]);
                for (int j = 0; j < rlen * 8; j++) bq.push_back(1'($urandom_range(0, 1)));
            end
            for (int j = 0; j < 10; j++) bq.push_back(1'($urandom_range(0, 1)));
            foreach (bq[j]) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)));
                ev_q.push_back('{cyc, bq[j]});
                step(1'b1, bq[j]);
            end
            repeat (4) step(1'b0, 1'b0);

            exp_q.delete();
            mode = 0; win = 8'd0; n = 0; acc = 8'd0; got = 0; pol = 1'b0; dcyc = -10; nfr = 0;
            foreach (ev_q[i]) begin
                if (mode == 2) begin
                    mode = 0; win = 8'd0; n = 0; pol = 1'b0;
                    if (ev_q[i].c == dcyc + 1) continue;
                end
                if (mode == 0) begin
                    win = {win[6:0], ev_q[i].b};
                    if (n < 8) n++;
                    if (n >= 8 && win == SYNC) begin
                        mode = 1; got = 0; pol = 1'b0;
                    end else if (INV && n >= 8 && win == ~SYNC) begin
                        mode = 1; got = 0; pol = 1'b1;
                    end
                end else begin
                    acc = {acc[6:0], ev_q[i].b ^ pol};
                    got++;
                    if (got % 8 == 0) exp_q.push_back(acc);
                    if (got == rlen * 8) begin
                        mode = 2; dcyc = ev_q[i].c; nfr++;
                    end
                end
            end

            check($sformatf("rnd%0d nbytes", run), got_q.size() - qb, exp_q.size());
            foreach (exp_q[i])
                if (qb + i < got_q.size())
                    check($sformatf("rnd%0d byte%0d", run, i), {24'd0, got_q[qb+i]}, {24'd0, exp_q[i]});
            check($sformatf("rnd%0d frames", run), fd_cnt - fb, nfr);
            check($sformatf("rnd%0d no ovf", run), ov_cnt - ob, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bpsk_rx_ctrl.md
BPSK_RX_CTRL -- requirements
Module: bpsk_rx_ctrl

Interface
REQ-001 Parameter SYNC_WORD, default 8'hD3: frame sync pattern, MSB received first.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 enable  input  1  receiver run; low forces IDLE.
REQ-005 sym_stb  input  1  one-cycle symbol strobe; bit_in valid when high.
REQ-006 bit_in  input  1  hard-decision bit from BPSK demodulator.
REQ-007 frame_len  input  4  payload bytes per frame, 1..15; 0 means 16; sampled on sync hit.
REQ-008 byte_ready  input  1  downstream accepts byte_data when high with byte_valid.
REQ-009 byte_data  output  8  assembled payload byte, first-received bit in MSB.
REQ-010 byte_valid  output  1  byte_data valid; held until accepted.
REQ-011 locked  output  1  high while in PAYLOAD state.
REQ-012 frame_done  output  1  one-cycle pulse after last payload byte assembled.
REQ-013 overflow  output  1  one-cycle pulse when an assembled byte is dropped.

Function
REQ-014 The FSM SHALL have states IDLE, HUNT, PAYLOAD, DONE.
REQ-015 IDLE -> HUNT on the first clock with enable=1; any state -> IDLE on any clock with enable=0, clearing shift register, counters, byte_valid.
REQ-016 HUNT: each sym_stb SHALL shift bit_in into an 8-bit register (LSB in) and increment a saturating bit count (0..8).
REQ-017 HUNT -> PAYLOAD on the clock where the updated register equals SYNC_WORD and the count reaches >=8; frame_len latched in that clock.
REQ-018 Sync check SHALL be suppressed until 8 bits have been shifted since HUNT entry, so reset zeros never match.
REQ-019 PAYLOAD: each sym_stb shifts bit_in into the byte assembler; on the 8th bit the byte completes.
REQ-020 Completed byte SHALL appear on byte_data with byte_valid=1 the clock after the 8th-bit strobe (latency 1 cycle).
REQ-021 byte_valid SHALL drop the clock after byte_valid&&byte_ready; byte_data stable while byte_valid high and not accepted.
REQ-022 If a byte completes while byte_valid=1 and byte_ready=0, the new byte SHALL be dropped and overflow pulsed for one cycle; held byte unchanged.
REQ-023 Acceptance and completion in the same cycle SHALL load the new byte with byte_valid remaining 1; no overflow.
REQ-024 Byte counter wraps per latched length; after the last byte completes the FSM SHALL enter DONE, pulse frame_done there, then return to HUNT with count cleared next cycle.
REQ-025 A pending byte_valid SHALL survive DONE->HUNT until accepted.
REQ-026 sym_stb in DONE SHALL be ignored.

Reset
REQ-027 While rst_n=0: state IDLE, byte_data=0, byte_valid=0, locked=0, frame_done=0, overflow=0, counters and shift registers 0.
REQ-028 Reset mid-frame SHALL discard partial byte and pending output; first post-reset action only when enable=1.

Configuration
REQ-029 Macro BPSK_RX_PHASE_INV_EN defined: HUNT also matches ~SYNC_WORD; on that match a polarity flag is set and all payload bits inverted before assembly; flag cleared on entering HUNT/IDLE.
REQ-030 Macro undefined: only SYNC_WORD matches, no inversion logic present.

Verification
REQ-031 enable=1, bits 1101_0011 then 0xA5, frame_len=1, byte_ready=1 -> locked after 8th strobe, byte_data=0xA5 valid 1 cycle after 16th strobe, frame_done pulse, back to HUNT.
REQ-032 frame_len=0, sync then 16 bytes 0x00..0x0F, byte_ready=1 -> 16 bytes in order, frame_done after 16th only.
REQ-033 frame_len=2, byte_ready=0 throughout -> byte_data=first byte held, overflow pulses once on second byte completion.
REQ-034 Same-cycle accept and completion (bytes 0x11,0x22 back-to-back strobes) -> byte_valid stays 1, 0x22 loaded, no overflow.
REQ-035 enable dropped mid-PAYLOAD, then rst_n pulsed -> IDLE, all outputs 0, next sync required to relock.
REQ-036 With BPSK_RX_PHASE_INV_EN: bits 0010_1100 then 0x5A -> byte_data=0xA5; without macro same stimulus -> no lock.
